sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO buffer for intra-domain traffic, the synchronous companion to the dual-clock FIFO. Adds an occupancy count, programmable almost-full/almost-empty thresholds and a synchronous flush. Data is show-ahead: the head word is always presented on `rdata`. Used wherever producer and consumer share one clock and need back-pressure with early warning.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `WIDTH`, 8: data width in bits, ≥ 1.
- `AFULL_THRESH`, 12: `afull` asserts when count ≥ this; range 1..DEPTH.
- `AEMPTY_THRESH`, 2: `aempty` asserts when count ≤ this; range 0..DEPTH-1.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  synchronous clear of pointers and count.
- `wdata`  in  WIDTH  write data.
- `wen`  in  1  write request.
- `full`  out  1  count == DEPTH.
- `afull`  out  1  count ≥ AFULL_THRESH.
- `rdata`  out  WIDTH  head-of-queue word (show-ahead).
- `ren`  in  1  read request; pops the word currently on `rdata`.
- `empty`  out  1  count == 0.
- `aempty`  out  1  count ≤ AEMPTY_THRESH.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`, `underflow`  out  1 each  sticky error flags (present only with `SYNC_FIFO_ERR_FLAGS_EN`).

## Operation
- State: write pointer, read pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH), count register, DEPTH×WIDTH memory.
- Write accepted iff `wen && !full && !flush`: mem[wptr] ← wdata, wptr+1.
- Read accepted iff `ren && !empty && !flush`: rptr+1.
- Count: +1 on write only, −1 on read only, unchanged on both or neither; never leaves 0..DEPTH.
- Simultaneous accepted read and write (0 < count < DEPTH): count unchanged, both pointers advance.
- `wen` while full: dropped, no state change. `ren` while empty: ignored, rptr unchanged.
- No write-through: at count 0, a write in cycle N is not visible on `rdata` until after edge N.
- `flush`: wptr, rptr, count → 0 next edge; memory contents untouched; overrides `wen`/`ren` that cycle.
- Flags `full`, `empty`, `afull`, `aempty` are combinational decodes of the count register only (no input-to-flag paths).
- `rdata` = mem[rptr], combinational from registered state.

## Timing
- Reset (`rst` high, asynchronous): pointers 0, count 0, all memory entries 0, sticky errors 0. Outputs during/after reset: `empty`=1, `aempty`=1, `full`=0, `afull`=0, `count`=0, `rdata`=0.
- Reset asserted mid-operation: all state clears immediately regardless of clock; pending requests lost.
- Write-to-read latency: 1 cycle (word written at edge N readable and `empty`=0 after edge N).
- Read: `rdata` valid in the same cycle `ren` is sampled; next word appears after the edge.
- All flag and `count` updates take effect after the edge on which the operation is accepted.
- Pointer wrap at DEPTH-1 → 0 requires no special handling; full/empty come from count, never pointer compare.

## Configuration
- `SYNC_FIFO_ERR_FLAGS_EN` defined: `overflow` and `underflow` ports exist. `overflow` sets on an edge with `wen && full && !flush`; `underflow` sets on `ren && empty && !flush`. Both stay set until `rst` or `flush`; `flush` clear wins over set in the same cycle.
- Not defined: ports and their logic are absent; dropped requests are silent.

## Test plan
(DEPTH=16, WIDTH=8, AFULL_THRESH=12, AEMPTY_THRESH=2.)
- Reset then idle → `empty`=1, `aempty`=1, `count`=0, `rdata`=0x00, `full`=0.
- Write 0x01..0x10 on consecutive cycles → `aempty` drops at count 3, `afull` rises at count 12, `full`=1 at 16; a 17th write of 0xFF is dropped, and with the macro `overflow`=1.
- From full, read 16 times → `rdata` sequence 0x01..0x10, `empty`=1 after the last read; a further `ren` leaves `count`=0 and sets `underflow` (macro on).
- At count 5, hold `wen`+`ren` for 40 cycles with incrementing data → `count` stays 5, pointers wrap twice, read order is preserved.
- At count 9, assert `flush` together with `wen`+`ren` → next cycle `count`=0, `empty`=1, sticky flags 0, the write is not stored.
- Pulse `rst` between clock edges at count 7 → outputs return to reset values immediately, before the next edge.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, almost-full/almost-empty
// thresholds and synchronous flush. Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow ports.
module sync_fifo #(
  parameter int DEPTH         = 16,
  parameter int WIDTH         = 8,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     wen,
  output logic                     full,
  output logic                     afull,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     ren,
  output logic                     empty,
  output logic                     aempty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic                     overflow,
  output logic                     underflow,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_wr_acc;
  logic w_rd_acc;

  // Flags decode the count register only, so no input reaches a flag combinationally.
  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign afull  = (r_count >= CW'(AFULL_THRESH));
  assign aempty = (r_count <= CW'(AEMPTY_THRESH));
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];

  assign w_wr_acc = wen && !full  && !flush;
  assign w_rd_acc = ren && !empty && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is reset so rdata reads zero after reset; this
  // forces flops rather than RAM macros, which is acceptable at these depths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_acc) begin
      r_mem[r_wptr] <= wdata;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Flush clears the sticky flags and takes priority over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wen && full)  r_overflow  <= 1'b1;
      if (ren && empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue-based reference model tracks the
// expected contents; honours SYNC_FIFO_ERR_FLAGS_EN for the sticky flags.
module tb_sync_fifo;

  localparam int DEPTH         = 16;
  localparam int WIDTH         = 8;
  localparam int AFULL_THRESH  = 12;
  localparam int AEMPTY_THRESH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             wen = 1'b0;
  logic             ren = 1'b0;
  logic             full, afull, empty, aempty;
  logic [WIDTH-1:0] rdata;
  logic [4:0]       count;
  logic             overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ov = 1'b0;
  logic             m_un = 1'b0;

  sync_fifo #(
    .DEPTH(DEPTH), .WIDTH(WIDTH),
    .AFULL_THRESH(AFULL_THRESH), .AEMPTY_THRESH(AEMPTY_THRESH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .wen(wen),
    .full(full), .afull(afull), .rdata(rdata), .ren(ren),
    .empty(empty), .aempty(aempty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .count(count)
  );

`ifndef SYNC_FIFO_ERR_FLAGS_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  always #5 clk = ~clk;

  // Apply one cycle of requests, advance the model on the edge, settle 1 ns.
  task automatic drive(input logic w, input logic [WIDTH-1:0] d,
                       input logic r, input logic f);
    int sz;
    wen = w; wdata = d; ren = r; flush = f;
    @(posedge clk);
    sz = q.size();
    if (f) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ov = 1'b1;
      if (r && sz == 0)     m_un = 1'b1;
      if (r && sz > 0)      void'(q.pop_front());
      if (w && sz < DEPTH)  q.push_back(d);
    end
    #1;
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || aempty !== 1'b1 || full !== 1'b0 ||
        afull !== 1'b0 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold: count=%0d empty=%b aempty=%b full=%b afull=%b rdata=%h, want 0 1 1 0 0 00",
               count, empty, aempty, full, afull, rdata);
    end
    #3 rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || aempty !== 1'b1 || full !== 1'b0 ||
        rdata !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: count=%0d empty=%b aempty=%b full=%b rdata=%h ov=%b un=%b",
               count, empty, aempty, full, rdata, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
      n_tests++;
      if (count !== 5'(i) || empty !== 1'b0 || full !== (i == DEPTH) ||
          afull !== (i >= AFULL_THRESH) || aempty !== (i <= AEMPTY_THRESH)) begin
        n_fail++;
        $display("FAIL fill[%0d]: count=%0d empty=%b full=%b afull=%b aempty=%b",
                 i, count, empty, full, afull, aempty);
      end
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    n_tests++;
    if (count !== 5'd16 || full !== 1'b1 || rdata !== 8'h01) begin
      n_fail++;
      $display("FAIL overflow_drop: count=%0d full=%b rdata=%h, want 16 1 01", count, full, rdata);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got %b want 1", overflow);
    end
`endif
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      n_tests++;
      if (rdata !== WIDTH'(i) || count !== 5'(DEPTH - i + 1)) begin
        n_fail++;
        $display("FAIL drain[%0d]: rdata=%h count=%0d want %h %0d",
                 i, rdata, count, WIDTH'(i), DEPTH - i + 1);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    n_tests++;
    if (empty !== 1'b1 || count !== 5'd0 || aempty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: empty=%b count=%0d aempty=%b", empty, count, aempty);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_ignore: count=%0d empty=%b want 0 1", count, empty);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    n_tests++;
    if (underflow !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_flag: un=%b ov=%b want 1 1", underflow, overflow);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 5; i++) drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    d = WIDTH'($urandom);
    for (int i = 0; i < 40; i++) begin
      n_tests++;
      if (rdata !== q[0]) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: rdata=%h want %h", i, rdata, q[0]);
      end
      drive(1'b1, d, 1'b1, 1'b0);
      d = d + 8'd1;
      n_tests++;
      if (count !== 5'd5) begin
        n_fail++;
        $display("FAIL b2b_count[%0d]: count=%0d want 5", i, count);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    n_tests++;
    if (count !== 5'd9) begin
      n_fail++;
      $display("FAIL flush_pre: count=%0d want 9", count);
    end
    drive(1'b1, 8'hAA, 1'b1, 1'b1);
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || aempty !== 1'b1 || full !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: count=%0d empty=%b aempty=%b full=%b ov=%b un=%b",
               count, empty, aempty, full, overflow, underflow);
    end
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    n_tests++;
    if (count !== 5'd1 || rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL flush_after: count=%0d rdata=%h want 1 3c", count, rdata);
    end
  endtask

  task automatic test_async_reset();
    while (q.size() < 7) drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    n_tests++;
    if (count !== 5'd7) begin
      n_fail++;
      $display("FAIL areset_pre: count=%0d want 7", count);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || aempty !== 1'b1 || full !== 1'b0 ||
        afull !== 1'b0 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_now: count=%0d empty=%b aempty=%b full=%b afull=%b rdata=%h",
               count, empty, aempty, full, afull, rdata);
    end
    #1 rst = 1'b0;
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (count !== 5'd0 || rdata !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_after: count=%0d rdata=%h ov=%b un=%b", count, rdata, overflow, underflow);
    end
  endtask

  task automatic test_random();
    logic w, r, f, bad;
    int   sz;
    for (int i = 0; i < 600; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 63) == 0);
      drive(w, WIDTH'($urandom), r, f);
      sz = q.size();
      bad = 1'b0;
      if (count !== 5'(sz)) bad = 1'b1;
      if (full !== (sz == DEPTH) || empty !== (sz == 0)) bad = 1'b1;
      if (afull !== (sz >= AFULL_THRESH) || aempty !== (sz <= AEMPTY_THRESH)) bad = 1'b1;
      if (sz > 0 && rdata !== q[0]) bad = 1'b1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      if (overflow !== m_ov || underflow !== m_un) bad = 1'b1;
`endif
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%0d want %0d full=%b empty=%b afull=%b aempty=%b rdata=%h want %h ov=%b/%b un=%b/%b",
                 i, count, sz, full, empty, afull, aempty, rdata,
                 (sz > 0) ? q[0] : 8'h00, overflow, m_ov, underflow, m_un);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
